// File: rtl/gates_pkg.sv
// Shared constants for the gates block: default operand width and the
// per-bit values the registered outputs take while in reset.
package gates_pkg;

    localparam int unsigned GATES_DEFAULT_WIDTH = 1;

    // Reset state equals the a=b=0 result: true outputs low, inverted outputs high.
    localparam logic RST_TRUE = 1'b0;
    localparam logic RST_INV  = 1'b1;

endpackage

// File: rtl/gates_if.sv
// Operand/result bundle for the gates block, with a driver (master) view
// and a gates-side (slave) view.
interface gates_if #(
    parameter int unsigned WIDTH = gates_pkg::GATES_DEFAULT_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] ya;
    logic [WIDTH-1:0] yna;
    logic [WIDTH-1:0] yo;
    logic [WIDTH-1:0] yno;
    logic [WIDTH-1:0] yx;
    logic [WIDTH-1:0] yxn;
    logic [WIDTH-1:0] ynota;
    logic [WIDTH-1:0] ynotb;

    modport master (
        output a, b,
        input  ya, yna, yo, yno, yx, yxn, ynota, ynotb
    );

    modport slave (
        input  a, b,
        output ya, yna, yo, yno, yx, yxn, ynota, ynotb
    );
endinterface

// File: rtl/gates_comb.sv
// Unregistered bitwise logic: eight results from operands a and b.
module gates_comb
    import gates_pkg::*;
#(
    parameter int unsigned WIDTH = GATES_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] ya,
    output logic [WIDTH-1:0] yna,
    output logic [WIDTH-1:0] yo,
    output logic [WIDTH-1:0] yno,
    output logic [WIDTH-1:0] yx,
    output logic [WIDTH-1:0] yxn,
    output logic [WIDTH-1:0] ynota,
    output logic [WIDTH-1:0] ynotb
);

    // Pure bitwise functions; complement pairs derived from one shared term.
    always_comb begin
        ya    = a & b;
        yna   = ~(a & b);
        yo    = a | b;
        yno   = ~(a | b);
        yx    = a ^ b;
        yxn   = ~(a ^ b);
        ynota = ~a;
        ynotb = ~b;
    end

endmodule

// File: rtl/gates.sv
// Registered bitwise gates: one flop stage on every result, synchronous
// active-high reset to the a=b=0 result.
module gates
    import gates_pkg::*;
#(
    parameter int unsigned WIDTH = GATES_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] ya,
    output logic [WIDTH-1:0] yna,
    output logic [WIDTH-1:0] yo,
    output logic [WIDTH-1:0] yno,
    output logic [WIDTH-1:0] yx,
    output logic [WIDTH-1:0] yxn,
    output logic [WIDTH-1:0] ynota,
    output logic [WIDTH-1:0] ynotb
);

    logic [WIDTH-1:0] ya_c, yna_c, yo_c, yno_c, yx_c, yxn_c, ynota_c, ynotb_c;

    gates_comb #(.WIDTH(WIDTH)) u_comb (
        .a     (a),
        .b     (b),
        .ya    (ya_c),
        .yna   (yna_c),
        .yo    (yo_c),
        .yno   (yno_c),
        .yx    (yx_c),
        .yxn   (yxn_c),
        .ynota (ynota_c),
        .ynotb (ynotb_c)
    );

    // Output register stage; reset overrides any operands sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ya    <= {WIDTH{RST_TRUE}};
            yo    <= {WIDTH{RST_TRUE}};
            yx    <= {WIDTH{RST_TRUE}};
            yna   <= {WIDTH{RST_INV}};
            yno   <= {WIDTH{RST_INV}};
            yxn   <= {WIDTH{RST_INV}};
            ynota <= {WIDTH{RST_INV}};
            ynotb <= {WIDTH{RST_INV}};
        end else begin
            ya    <= ya_c;
            yna   <= yna_c;
            yo    <= yo_c;
            yno   <= yno_c;
            yx    <= yx_c;
            yxn   <= yxn_c;
            ynota <= ynota_c;
            ynotb <= ynotb_c;
        end
    end

endmodule

// File: tb/tb_gates.sv
// Scoreboard bench for gates: WIDTH=1 and WIDTH=8 instances share stimulus
// (the 1-bit instance sees bit 0 of the 8-bit operands).
module tb_gates;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    gates_if #(.WIDTH(1)) if1 ();
    gates_if #(.WIDTH(8)) if8 ();

    gates #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(if1.a), .b(if1.b),
        .ya(if1.ya), .yna(if1.yna), .yo(if1.yo), .yno(if1.yno),
        .yx(if1.yx), .yxn(if1.yxn), .ynota(if1.ynota), .ynotb(if1.ynotb)
    );

    gates #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(if8.a), .b(if8.b),
        .ya(if8.ya), .yna(if8.yna), .yo(if8.yo), .yno(if8.yno),
        .yx(if8.yx), .yxn(if8.yxn), .ynota(if8.ynota), .ynotb(if8.ynotb)
    );

    // Expected result set, packed as {ya,yna,yo,yno,yx,yxn,ynota,ynotb}, 8 bits each.
    localparam logic [63:0] RESET_EXP = 64'h00FF_00FF_00FF_FFFF;

    logic [63:0] sb [$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [63:0] model(input logic [7:0] a, input logic [7:0] b);
        return {a & b, ~(a & b), a | b, ~(a | b), a ^ b, ~(a ^ b), ~a, ~b};
    endfunction

    // Bit 0 of each field, i.e. what the 1-bit instance should show.
    function automatic logic [7:0] lsbs(input logic [63:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[8*i];
        return r;
    endfunction

    function automatic logic [63:0] obs8();
        return {if8.ya, if8.yna, if8.yo, if8.yno, if8.yx, if8.yxn, if8.ynota, if8.ynotb};
    endfunction

    function automatic logic [7:0] obs1();
        return {if1.ya, if1.yna, if1.yo, if1.yno, if1.yx, if1.yxn, if1.ynota, if1.ynotb};
    endfunction

    // Apply one operand set before the next rising edge and record its expected result.
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic r,
                         input logic [63:0] exp);
        @(negedge clk);
        if8.a = a;
        if8.b = b;
        if1.a = a[0];
        if1.b = b[0];
        rst   = r;
        sb.push_back(exp);
    endtask

    task automatic test_reset();
        logic [63:0] e;
        for (int i = 0; i < 2; i++) begin
            drive(8'hFF, 8'hFF, 1'b1, RESET_EXP);
            @(posedge clk); #1;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++; $display("FAIL reset_sb: got empty scoreboard, required an entry");
            end else begin
                e = sb.pop_front();
                if (obs8() !== e) begin
                    n_fail++; $display("FAIL reset_w8[%0d]: got %h required %h", i, obs8(), e);
                end
                n_checks++;
                if (obs1() !== lsbs(e)) begin
                    n_fail++; $display("FAIL reset_w1[%0d]: got %b required %b", i, obs1(), lsbs(e));
                end
            end
        end
    endtask

    task automatic test_truth_table();
        // Columns per row: ya, yo, yx, ynota, ynotb for (a,b) = 00, 10, 01, 11.
        logic [4:0] tt [4] = '{5'b00011, 5'b01101, 5'b01110, 5'b11000};
        logic [1:0] ab [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
        logic [63:0] e;
        for (int i = 0; i < 4; i++) begin
            drive({8{ab[i][1]}}, {8{ab[i][0]}}, 1'b0, model({8{ab[i][1]}}, {8{ab[i][0]}}));
            @(posedge clk); #1;
            n_checks++;
            if ({if1.ya, if1.yo, if1.yx, if1.ynota, if1.ynotb} !== tt[i]) begin
                n_fail++;
                $display("FAIL truth_const ab=%b: got %b required %b", ab[i],
                         {if1.ya, if1.yo, if1.yx, if1.ynota, if1.ynotb}, tt[i]);
            end
            n_checks++;
            if ((if1.yna !== ~if1.ya) || (if1.yno !== ~if1.yo) || (if1.yxn !== ~if1.yx)) begin
                n_fail++; $display("FAIL truth_compl ab=%b: got %b", ab[i], obs1());
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                if (obs8() !== e) begin
                    n_fail++; $display("FAIL truth_w8 ab=%b: got %h required %h", ab[i], obs8(), e);
                end
            end
        end
    endtask

    task automatic test_latency();
        logic [63:0] e;
        drive(8'h00, 8'hFF, 1'b0, model(8'h00, 8'hFF));
        @(posedge clk); #1;
        if (sb.size() != 0) e = sb.pop_front();
        drive(8'hFF, 8'hFF, 1'b0, model(8'hFF, 8'hFF));
        #1;
        n_checks++;
        if (if1.ya !== 1'b0 || if8.ya !== 8'h00) begin
            n_fail++; $display("FAIL latency_before: got %b/%h required 0/00", if1.ya, if8.ya);
        end
        @(posedge clk); #1;
        n_checks++;
        if (if1.ya !== 1'b1 || if8.ya !== 8'hFF) begin
            n_fail++; $display("FAIL latency_after: got %b/%h required 1/ff", if1.ya, if8.ya);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            if (obs8() !== e) begin
                n_fail++; $display("FAIL latency_w8: got %h required %h", obs8(), e);
            end
        end
    endtask

    task automatic test_width8();
        logic [63:0] e;
        drive(8'hF0, 8'hCC, 1'b0, 64'hC03F_FC03_3CC3_0F33);
        @(posedge clk); #1;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++; $display("FAIL width8_sb: got empty scoreboard, required an entry");
        end else begin
            e = sb.pop_front();
            if (obs8() !== e) begin
                n_fail++; $display("FAIL width8_f0cc: got %h required %h", obs8(), e);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [63:0] e;
        drive(8'hFF, 8'hFF, 1'b0, model(8'hFF, 8'hFF));
        drive(8'hFF, 8'hFF, 1'b1, RESET_EXP);
        drive(8'hFF, 8'hFF, 1'b0, model(8'hFF, 8'hFF));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        // The three drives above each consume one edge; re-run with per-edge checks.
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            drive(8'hFF, 8'hFF, (i == 1), (i == 1) ? RESET_EXP : model(8'hFF, 8'hFF));
            @(posedge clk); #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                if (obs8() !== e) begin
                    n_fail++; $display("FAIL midrst_w8[%0d]: got %h required %h", i, obs8(), e);
                end
                n_checks++;
                if (obs1() !== lsbs(e)) begin
                    n_fail++; $display("FAIL midrst_w1[%0d]: got %b required %b", i, obs1(), lsbs(e));
                end
            end
        end
        n_checks++;
        if (if1.ya !== 1'b1 || if1.yx !== 1'b0) begin
            n_fail++; $display("FAIL midrst_release: got ya=%b yx=%b required ya=1 yx=0", if1.ya, if1.yx);
        end
    endtask

    task automatic test_glitch_hold();
        logic [63:0] e;
        drive(8'h5A, 8'h3C, 1'b0, model(8'h5A, 8'h3C));
        @(posedge clk); #1;
        e = (sb.size() != 0) ? sb.pop_front() : 64'hx;
        if1.a = ~if1.a; if8.a = ~if8.a; #1;
        if1.a = ~if1.a; if8.a = ~if8.a; #1;
        if1.a = ~if1.a; if8.a = ~if8.a; #1;
        n_checks++;
        if (obs8() !== e || obs1() !== lsbs(e)) begin
            n_fail++; $display("FAIL glitch_hold: got %h/%b required %h/%b", obs8(), obs1(), e, lsbs(e));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a, b;
        logic [63:0] e;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            drive(a, b, 1'b0, model(a, b));
            @(posedge clk); #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                if (obs8() !== e || obs1() !== lsbs(e)) begin
                    n_fail++;
                    $display("FAIL b2b[%0d] a=%h b=%h: got %h/%b required %h/%b",
                             i, a, b, obs8(), obs1(), e, lsbs(e));
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL b2b_drain: got %0d leftover entries required 0", sb.size());
        end
    endtask

    initial begin
        if1.a = '0; if1.b = '0;
        if8.a = '0; if8.b = '0;
        test_reset();
        test_truth_table();
        test_latency();
        test_width8();
        test_mid_reset();
        test_glitch_hold();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gates.md
GATES -- requirements
Module: gates

Interface
- REQ-001: Parameter WIDTH, default 1, SHALL set the bit width of the operands and of every result output.
- REQ-002: Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
- REQ-003: Port rst, input, 1 bit, SHALL be the reset: synchronous, active-high.
- REQ-004: Port a, input, WIDTH bits, SHALL be operand A.
- REQ-005: Port b, input, WIDTH bits, SHALL be operand B.
- REQ-006: Port ya, output, WIDTH bits, SHALL carry registered a AND b.
- REQ-007: Port yna, output, WIDTH bits, SHALL carry registered NOT(a AND b).
- REQ-008: Port yo, output, WIDTH bits, SHALL carry registered a OR b.
- REQ-009: Port yno, output, WIDTH bits, SHALL carry registered NOT(a OR b).
- REQ-010: Port yx, output, WIDTH bits, SHALL carry registered a XOR b.
- REQ-011: Port yxn, output, WIDTH bits, SHALL carry registered NOT(a XOR b).
- REQ-012: Port ynota, output, WIDTH bits, SHALL carry registered NOT a.
- REQ-013: Port ynotb, output, WIDTH bits, SHALL carry registered NOT b.
- REQ-014: Port order SHALL be clk, rst, a, b, ya, yna, yo, yno, yx, yxn, ynota, ynotb.

Function
- REQ-015: All eight results SHALL be computed bitwise; bit i of each output depends only on bit i of a and b.
- REQ-016: Each output SHALL be a flip-flop stage; latency is exactly 1 clk cycle from a/b sampled at edge N to the output valid after edge N.
- REQ-017: Outputs SHALL hold their value between rising edges regardless of a/b activity; no combinational path from a/b to any output.
- REQ-018: A new operand pair SHALL be accepted every cycle; throughput is 1 result set per cycle, no handshake.
- REQ-019: Per bit, the output pairs SHALL always be complementary: yna = ~ya, yno = ~yo, yxn = ~yx.
- REQ-020: If rst and an operand change coincide at the same edge, rst SHALL win; operands sampled at that edge are discarded.
- REQ-021: Outputs SHALL not depend on X-free history; the result depends only on a/b at the last non-reset edge.

Reset
- REQ-022: At a rising clk edge with rst=1, outputs SHALL load the a=b=0 result: ya, yo, yx all zeros; yna, yno, yxn, ynota, ynotb all ones.
- REQ-023: The first rising edge with rst=0 SHALL register results from the current a/b.
- REQ-024: Asserting rst mid-operation SHALL take effect on the next edge with no partial update of any output.

Structure
- REQ-025: Package gates_pkg SHALL hold the default WIDTH constant and the reset-value constants for the true and the inverted outputs.
- REQ-026: Combinational logic SHALL be in one sub-module, gates_comb: inputs a, b; eight unregistered results. The top gates SHALL instantiate it and add the output register stage with reset.

Verification
- REQ-027: Reset: rst=1 for 2 edges, a=b=1 -> ya=yo=yx=0, yna=yno=yxn=ynota=ynotb=1.
- REQ-028: WIDTH=1 truth table: (a,b) = 00, 10, 01, 11, one pair per cycle -> one cycle later ya=0,0,0,1; yo=0,1,1,1; yx=0,1,1,0; ynota=1,0,1,0; ynotb=1,1,0,0; complements per REQ-019.
- REQ-029: Latency: change a 0->1 with b=1 at edge N -> ya is 0 before edge N+1 and 1 after edge N+1.
- REQ-030: WIDTH=8: a=8'hF0, b=8'hCC -> ya=8'hC0, yo=8'hFC, yx=8'h3C, yna=8'h3F, yno=8'h03, yxn=8'hC3, ynota=8'h0F, ynotb=8'h33.
- REQ-031: Mid-stream reset: a=b=1 steady, assert rst for 1 edge -> reset values for one cycle, then ya=1, yx=0 on the following edge.
- REQ-032: Glitch hold: toggle a twice between edges -> outputs unchanged until the next edge.
